// File: rtl/candsel_pkg.sv
// Shared widths and FSM state for the candidate selector.
// Optional runner-up tracking: CANDSEL_SECOND_BEST_EN.
package candsel_pkg;

    function automatic int awidth(input int a);
        return $clog2(a) + 1;
    endfunction

    function automatic int swidth(input int cw, input int j);
        return cw + $clog2(j) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/candsel_if.sv
// Candidate stream in, best-candidate result out.
// Runner-up signals exist only with CANDSEL_SECOND_BEST_EN.
interface candsel_if #(
    parameter int J     = 14,
    parameter int A     = 2,
    parameter int CW    = 8,
    parameter int CNT_W = 16
);
    import candsel_pkg::*;

    localparam int AWIDTH = awidth(A);
    localparam int SW     = swidth(CW, J);

    logic [J*AWIDTH-1:0] candidate_row;
    logic                candidate_row_tvalid;
    logic                candidate_row_tlast;

    logic [J*AWIDTH-1:0] result_row;
    logic [SW-1:0]       result_score;
    logic [CNT_W-1:0]    result_idx;
    logic                result_tvalid;
    logic                result_tready;
`ifdef CANDSEL_SECOND_BEST_EN
    logic [J*AWIDTH-1:0] second_row;
    logic [SW-1:0]       second_score;
`endif

    modport master (
        output candidate_row, candidate_row_tvalid, candidate_row_tlast,
        output result_tready,
        input  result_row, result_score, result_idx, result_tvalid
`ifdef CANDSEL_SECOND_BEST_EN
        , input second_row, second_score
`endif
    );

    modport slave (
        input  candidate_row, candidate_row_tvalid, candidate_row_tlast,
        input  result_tready,
        output result_row, result_score, result_idx, result_tvalid
`ifdef CANDSEL_SECOND_BEST_EN
        , output second_row, second_score
`endif
    );

endinterface

// File: rtl/candsel_adder_tree.sv
// Sums J per-symbol costs into one registered full-width score.
module candsel_adder_tree
    import candsel_pkg::*;
#(
    parameter int J  = 14,
    parameter int CW = 8,
    localparam int SW = swidth(CW, J)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [J*CW-1:0] costs,
    output logic            out_valid,
    output logic [SW-1:0]   sum
);

    logic [SW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int j = 0; j < J; j++) begin
            acc = acc + SW'(costs[j*CW +: CW]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) sum <= acc;
        end
    end

endmodule

// File: rtl/candidate_select.sv
// Streams candidate rows, scores them against a cost table, reports the cheapest.
// CANDSEL_SECOND_BEST_EN adds runner-up row/score outputs.
module candidate_select
    import candsel_pkg::*;
#(
    parameter int J     = 14,
    parameter int A     = 2,
    parameter int CW    = 8,
    parameter int CNT_W = 16,
    localparam int AWIDTH = awidth(A),
    localparam int SW     = swidth(CW, J)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [J*A*CW-1:0] cost_table,
    input  logic              cost_tvalid,
    candsel_if.slave          bus,
    input  logic              clr_status,
    output logic              err_sym,
    output logic              overrun
);

    localparam int RW = J * AWIDTH;

    state_t state_q, state_d;
    logic   dcnt_q, dcnt_d;

    logic [J*A*CW-1:0] cost_q;
    logic              beat, first, last;
    logic [CNT_W-1:0]  cur_idx, nxt_idx;
    logic [J*CW-1:0]   lk;
    logic              bad;
    logic [AWIDTH-1:0] sym;

    logic             s1_v, s1_first, s1_last;
    logic [RW-1:0]    s1_row;
    logic [CNT_W-1:0] s1_idx;
    logic [J*CW-1:0]  s1_cost;

    logic             s2_v, s2_first, s2_last;
    logic [RW-1:0]    s2_row;
    logic [CNT_W-1:0] s2_idx;
    logic [SW-1:0]    s2_sum;

    logic [RW-1:0]    best_row;
    logic [SW-1:0]    best_score;
    logic [CNT_W-1:0] best_idx;
    logic             fin_q;

    logic [RW-1:0]    res_row;
    logic [SW-1:0]    res_score;
    logic [CNT_W-1:0] res_idx;
    logic             res_v;

    assign beat    = bus.candidate_row_tvalid;
    assign last    = bus.candidate_row_tlast;
    assign first   = (state_q != ACCUM);
    assign cur_idx = first ? '0 : nxt_idx;

    always_comb begin
        state_d = state_q;
        dcnt_d  = 1'b0;
        unique case (state_q)
            IDLE: if (beat) state_d = last ? DRAIN : ACCUM;
            ACCUM: if (beat && last) state_d = DRAIN;
            DRAIN: begin
                if (beat) state_d = last ? DRAIN : ACCUM;
                else if (dcnt_q) state_d = IDLE;
                else dcnt_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dcnt_q  <= 1'b0;
            cost_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            if (cost_tvalid && state_q == IDLE) cost_q <= cost_table;
        end
    end

    // Out-of-alphabet symbols cost the maximum and are flagged.
    always_comb begin
        lk  = '0;
        bad = 1'b0;
        sym = '0;
        for (int j = 0; j < J; j++) begin
            sym = bus.candidate_row[j*AWIDTH +: AWIDTH];
            if (int'(sym) >= A) begin
                lk[j*CW +: CW] = '1;
                bad = 1'b1;
            end else begin
                for (int a = 0; a < A; a++) begin
                    if (int'(sym) == a)
                        lk[j*CW +: CW] = cost_q[(j*A+a)*CW +: CW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_row   <= '0;
            s1_idx   <= '0;
            s1_cost  <= '0;
            nxt_idx  <= '0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_row   <= '0;
            s2_idx   <= '0;
        end else begin
            s1_v <= beat;
            if (beat) begin
                s1_first <= first;
                s1_last  <= last;
                s1_row   <= bus.candidate_row;
                s1_idx   <= cur_idx;
                s1_cost  <= lk;
                nxt_idx  <= (cur_idx == '1) ? cur_idx : cur_idx + 1'b1;
            end
            if (s1_v) begin
                s2_first <= s1_first;
                s2_last  <= s1_last;
                s2_row   <= s1_row;
                s2_idx   <= s1_idx;
            end
        end
    end

    candsel_adder_tree #(.J(J), .CW(CW)) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_v),
        .costs     (s1_cost),
        .out_valid (s2_v),
        .sum       (s2_sum)
    );

`ifdef CANDSEL_SECOND_BEST_EN
    logic          sec_v;
    logic [RW-1:0] sec_row;
    logic [SW-1:0] sec_score;
    logic [RW-1:0] res2_row;
    logic [SW-1:0] res2_score;

    assign bus.second_row   = res2_row;
    assign bus.second_score = res2_score;
`endif

    // Strict less-than keeps the earliest candidate on ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_row   <= '0;
            best_score <= '0;
            best_idx   <= '0;
            fin_q      <= 1'b0;
`ifdef CANDSEL_SECOND_BEST_EN
            sec_v      <= 1'b0;
            sec_row    <= '0;
            sec_score  <= '0;
`endif
        end else begin
            fin_q <= s2_v && s2_last;
            if (s2_v) begin
                if (s2_first || s2_sum < best_score) begin
                    best_row   <= s2_row;
                    best_score <= s2_sum;
                    best_idx   <= s2_idx;
`ifdef CANDSEL_SECOND_BEST_EN
                    sec_v     <= !s2_first;
                    sec_row   <= best_row;
                    sec_score <= best_score;
`endif
                end
`ifdef CANDSEL_SECOND_BEST_EN
                else if (!sec_v || s2_sum < sec_score) begin
                    sec_v     <= 1'b1;
                    sec_row   <= s2_row;
                    sec_score <= s2_sum;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_row   <= '0;
            res_score <= '0;
            res_idx   <= '0;
            res_v     <= 1'b0;
            err_sym   <= 1'b0;
            overrun   <= 1'b0;
`ifdef CANDSEL_SECOND_BEST_EN
            res2_row   <= '0;
            res2_score <= '0;
`endif
        end else begin
            if (fin_q) begin
                res_row   <= best_row;
                res_score <= best_score;
                res_idx   <= best_idx;
                res_v     <= 1'b1;
`ifdef CANDSEL_SECOND_BEST_EN
                res2_row   <= sec_v ? sec_row : '0;
                res2_score <= sec_v ? sec_score : '0;
`endif
            end else if (res_v && bus.result_tready) begin
                res_row   <= '0;
                res_score <= '0;
                res_idx   <= '0;
                res_v     <= 1'b0;
`ifdef CANDSEL_SECOND_BEST_EN
                res2_row   <= '0;
                res2_score <= '0;
`endif
            end
            err_sym <= (beat && bad) || (err_sym && !clr_status);
            overrun <= (fin_q && res_v && !bus.result_tready)
                    || (overrun && !clr_status);
        end
    end

    assign bus.result_row    = res_row;
    assign bus.result_score  = res_score;
    assign bus.result_idx    = res_idx;
    assign bus.result_tvalid = res_v;

endmodule

// File: doc/candidate_select.md
CANDIDATE_SELECT -- requirements
Module: candidate_select

Interface
REQ-001 SHALL have parameter J, default 14, meaning symbols per candidate row.
REQ-002 SHALL have parameter A, default 2, meaning alphabet size; AWIDTH = $clog2(A)+1.
REQ-003 SHALL have parameter CW, default 8, meaning per-symbol cost width; SW = CW+$clog2(J)+1.
REQ-004 SHALL have parameter CNT_W, default 16, meaning candidate index width.
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 reset, synchronous, active-low.
REQ-006 SHALL have ports: cost_table in J*A*CW, entry (j,a) at [(j*A+a)*CW +: CW]; cost_tvalid in 1, load strobe.
REQ-007 SHALL have ports: candidate_row in J*AWIDTH, symbol j at [j*AWIDTH +: AWIDTH]; candidate_row_tvalid in 1; candidate_row_tlast in 1.
REQ-008 SHALL have ports: result_row out J*AWIDTH; result_score out SW; result_idx out CNT_W; result_tvalid out 1; result_tready in 1.
REQ-009 SHALL have ports: clr_status in 1; err_sym out 1 sticky; overrun out 1 sticky.

Function
REQ-010 SHALL accept every beat with candidate_row_tvalid=1; no backpressure upstream.
REQ-011 SHALL score each beat as the sum over j of cost[j][symbol j], computed at full SW width with no overflow.
REQ-012 SHALL treat a symbol >= A as cost {CW{1}} and set err_sym.
REQ-013 SHALL pipeline in three stages: S1 registers the looked-up costs, row, first/last tags and idx; S2 registers the sum; S3 does the compare/update.
REQ-014 SHALL tag the first beat of a stream (first valid beat after reset or after a tlast beat) and assign idx 0, incrementing per beat and saturating at 2^CNT_W-1.
REQ-015 SHALL, in S3, load the running best from a first-tagged beat unconditionally; otherwise it SHALL replace the running best only on strictly smaller score, so ties keep the earliest candidate.
REQ-016 SHALL, in S3 on a last-tagged beat, copy the final best to the result registers and assert result_tvalid; the rise SHALL occur on the third clk edge after the edge sampling the tlast beat.
REQ-017 SHALL handle a single-beat stream (first and last together) by outputting that beat with idx 0.
REQ-018 SHALL hold result_* stable while result_tvalid=1 and result_tready=0; the result clears on the edge where both are 1.
REQ-019 SHALL accept a new stream while a result is pending or the pipeline is draining, because running and result registers are separate.
REQ-020 SHALL, if a new result completes while result_tvalid=1 and result_tready=0, overwrite the result, keep result_tvalid=1 and set overrun; if result_tready=1 on that edge, SHALL present the new result with no overrun.
REQ-021 SHALL implement FSM IDLE->ACCUM on the first beat, ACCUM->DRAIN on a tlast beat, DRAIN->IDLE after 2 cycles, and DRAIN->ACCUM on a beat arriving in DRAIN.
REQ-022 SHALL apply cost_tvalid only in IDLE and ignore it in ACCUM/DRAIN.
REQ-023 SHALL clear err_sym and overrun with clr_status; a same-cycle set SHALL win.

Reset
REQ-024 SHALL clear on rst_n=0: FSM to IDLE, cost table, pipeline valid bits, running best, all result_* to 0, result_tvalid, err_sym and overrun.
REQ-025 SHALL discard in-flight beats on reset mid-stream; the next valid beat is a first beat.

Configuration
REQ-026 SHALL, with CANDSEL_SECOND_BEST_EN defined, add outputs second_row (J*AWIDTH) and second_score (SW) tracking the runner-up (a tie with the best goes to second if earlier-best held), valid with result_tvalid and 0 for single-beat streams, reset to 0.
REQ-027 SHALL, without CANDSEL_SECOND_BEST_EN, omit these ports and their logic, leaving all other behaviour identical.

Structure
REQ-028 SHALL put AWIDTH/SW derivation functions and the FSM state enum in package candsel_pkg.
REQ-029 SHALL have one sub-module, candsel_adder_tree (J CW-bit inputs to a registered SW-bit sum), implementing S2.

Verification
REQ-030 SHALL cover: cost[j][1]=j+1, cost[j][0]=0, stream of 14 rows each with a single 1 at j -> result_idx 0, score 1, result_tvalid 3 edges after tlast.
REQ-031 SHALL cover: two candidates scoring 5, idx 2 and 6 -> result_idx 2.
REQ-032 SHALL cover: result_tready=0 while a second stream completes -> overrun=1 and second result shown; clr_status -> overrun=0.
REQ-033 SHALL cover: symbol value 3 with A=2 -> err_sym=1 and that row contributes 255.
REQ-034 SHALL cover: back-to-back streams with no idle cycle and a single-beat stream -> independent correct results; cost_tvalid in ACCUM is ignored.
REQ-035 SHALL cover: rst_n low mid-stream -> no result_tvalid, and the next stream restarts at idx 0.
